// File: rtl/fifo_rd_pkg.sv
// Shared sizing helpers and in-flight slot type for the FIFO stream reader.
package fifo_rd_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // One issued FIFO read travelling towards the buffer; discard marks reads overtaken by a flush.
  typedef struct packed {
    logic issued;
    logic discard;
  } inflight_t;

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

  function automatic int buf_depth(input int lat);
    return lat + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the reader (master) and its environment (slave).
interface fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic             fifo_re;
  logic [WIDTH-1:0] fifo_dout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output fifo_re, out_valid, out_data,
    input  fifo_empty, fifo_dout, out_ready
  );

  modport slave (
    input  fifo_re, out_valid, out_data,
    output fifo_empty, fifo_dout, out_ready
  );
endinterface

// File: rtl/stream_prefetch_buf.sv
// Small circular prefetch buffer; the head entry drives the downstream stream directly.
module stream_prefetch_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int OCC_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_valid = (occ != '0);
  assign head_data  = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a simple_fifo through a credit-limited prefetch buffer and presents a valid/ready stream.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     word_count
);

  // An illegal latency falls back to 1 so the datapath stays well formed.
  localparam int LAT       = rd_latency_legal(RD_LATENCY) ? RD_LATENCY : 1;
  localparam int BUF_DEPTH = buf_depth(LAT);
  localparam int OCC_W     = occ_w(BUF_DEPTH);

  inflight_t        inflight_p [LAT];
  logic [OCC_W-1:0] occ;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             push;
  logic             credit_ok;
  int               inflight_n;

  assign pop  = head_valid & bus.out_ready;
  assign push = inflight_p[LAT-1].issued & ~inflight_p[LAT-1].discard & ~flush;

  always_comb begin
    inflight_n = 0;
    for (int i = 0; i < LAT; i++)
      if (inflight_p[i].issued && !inflight_p[i].discard) inflight_n = inflight_n + 1;
    credit_ok = (int'(occ) + inflight_n) < (BUF_DEPTH + int'(pop));
  end

  assign bus.fifo_re = reset & enable & ~bus.fifo_empty & ~flush & credit_ok;

  // Read issue -> land: one slot per cycle of FIFO read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) inflight_p[i] <= '0;
      word_count <= '0;
    end else begin
      inflight_p[0] <= '{issued: bus.fifo_re, discard: 1'b0};
      for (int i = 1; i < LAT; i++)
        inflight_p[i] <= '{issued: inflight_p[i-1].issued, discard: inflight_p[i-1].discard | flush};
      if (pop) word_count <= word_count + CNT_W'(1);
    end
  end

  stream_prefetch_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_data  (bus.fifo_dout),
    .pop        (pop),
    .occ        (occ),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a latency-1 reader with a 4-bit counter and a latency-2 reader under random traffic.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic reset;
  logic enable_a, flush_a, enable_b, flush_b;
  logic [3:0]  wc_a;
  logic [31:0] wc_b;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(32)) ia ();
  fifo_stream_reader_if #(.WIDTH(32)) ib ();

  fifo_stream_reader #(.WIDTH(32), .RD_LATENCY(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .flush(flush_a), .bus(ia), .word_count(wc_a)
  );

  fifo_stream_reader #(.WIDTH(32), .RD_LATENCY(2), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .flush(flush_b), .bus(ib), .word_count(wc_b)
  );

  // FIFO model A: one-cycle read latency over a preloaded array
  logic [31:0] fa_mem [256];
  int fa_wp = 0;
  int fa_rp = 0;
  assign ia.fifo_empty = (fa_wp == fa_rp);
  always @(posedge clk) begin
    if (ia.fifo_re) begin
      ia.fifo_dout <= fa_mem[fa_rp % 256];
      fa_rp <= fa_rp + 1;
    end
  end

  // FIFO model B: two-cycle read latency, endless incrementing data, empty flag driven by the bench
  logic        fb_block = 1'b1;
  logic [31:0] fb_d1;
  int          fb_rp = 0;
  assign ib.fifo_empty = fb_block;
  always @(posedge clk) begin
    if (ib.fifo_re) begin
      fb_d1 <= 32'hB000_0000 + 32'(fb_rp);
      fb_rp <= fb_rp + 1;
    end
    ib.fifo_dout <= fb_d1;
  end

  int checks = 0;
  int errors = 0;
  int cyc_idx, re_cnt_a, pops_a, first_pop_a, last_pop_a;
  logic [31:0] exp_a;
  logic        s_re, s_valid;
  logic [31:0] s_data;
  int issued_b, pops_b;
  logic [31:0] exp_b, held_data_b;
  logic        hold_b, s_valid_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] v);
    fa_mem[fa_wp % 256] = v;
    fa_wp++;
  endtask

  task automatic cyc_a(input logic rdy);
    ia.out_ready = rdy;
    #1;
    s_re    = ia.fifo_re;
    s_valid = ia.out_valid;
    s_data  = ia.out_data;
    check("a_re_on_empty", 64'(ia.fifo_re & ia.fifo_empty), 64'd0);
    if (ia.fifo_re) re_cnt_a++;
    if (ia.out_valid && ia.out_ready) begin
      check("a_data", 64'(ia.out_data), 64'(exp_a));
      exp_a++;
      pops_a++;
      if (first_pop_a < 0) first_pop_a = cyc_idx;
      last_pop_a = cyc_idx;
    end
    cyc_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    cyc_idx = 0; re_cnt_a = 0; pops_a = 0; first_pop_a = -1; last_pop_a = -1;
  endtask

  task automatic cyc_b(input logic rdy, input logic blk);
    ib.out_ready = rdy;
    fb_block     = blk;
    #1;
    check("b_re_on_empty", 64'(ib.fifo_re & ib.fifo_empty), 64'd0);
    if (hold_b) begin
      check("b_valid_hold", 64'(ib.out_valid), 64'd1);
      check("b_data_hold", 64'(ib.out_data), 64'(held_data_b));
    end
    if (ib.fifo_re) issued_b++;
    if (ib.out_valid && ib.out_ready) begin
      check("b_data", 64'(ib.out_data), 64'(exp_b));
      exp_b++;
      pops_b++;
    end
    check("b_no_overrun", 64'((issued_b - pops_b) <= 3), 64'd1);
    hold_b      = ib.out_valid && !ib.out_ready;
    held_data_b = ib.out_data;
    s_valid_b   = ib.out_valid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable_a = 1'b1; flush_a = 1'b0; enable_b = 1'b0; flush_b = 1'b0;
    ia.out_ready = 1'b1; ib.out_ready = 1'b0;
    hold_b = 1'b0; issued_b = 0; pops_b = 0; exp_b = 32'hB000_0000;
    for (int v = 1; v <= 8; v++) push_a(32'(v));
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a non-empty FIFO
    check("rst_re", 64'(ia.fifo_re), 64'd0);
    check("rst_valid", 64'(ia.out_valid), 64'd0);
    check("rst_data", 64'(ia.out_data), 64'd0);
    check("rst_count", 64'(wc_a), 64'd0);
    check("rst_valid_b", 64'(ib.out_valid), 64'd0);
    check("rst_count_b", 64'(wc_b), 64'd0);

    // Streaming 1..8 with a ready consumer
    reset = 1'b1;
    clr_a();
    exp_a = 32'd1;
    for (int i = 0; i < 12; i++) cyc_a(1'b1);
    check("stream_first_pop", 64'(first_pop_a), 64'd2);
    check("stream_last_pop", 64'(last_pop_a), 64'd9);
    check("stream_pops", 64'(pops_a), 64'd8);
    check("stream_reads", 64'(re_cnt_a), 64'd8);
    check("stream_count", 64'(wc_a), 64'd8);

    // Backpressure: buffer fills with two reads, head holds, then drains 9..20
    for (int v = 9; v <= 20; v++) push_a(32'(v));
    clr_a();
    for (int i = 0; i < 10; i++) begin
      cyc_a(1'b0);
      if (s_valid) check("bp_hold_data", 64'(s_data), 64'd9);
    end
    check("bp_reads", 64'(re_cnt_a), 64'd2);
    check("bp_valid", 64'(s_valid), 64'd1);
    for (int i = 0; i < 16; i++) cyc_a(1'b1);
    check("bp_pops", 64'(pops_a), 64'd12);
    check("bp_count", 64'(wc_a), 64'd4);
    check("bp_drained", 64'(s_valid), 64'd0);

    // Flush the cycle after a read: 21 is dropped, 22 and 23 follow
    for (int v = 21; v <= 23; v++) push_a(32'(v));
    clr_a();
    cyc_a(1'b0);
    check("fl_read_issued", 64'(s_re), 64'd1);
    flush_a = 1'b1;
    cyc_a(1'b0);
    check("fl_re_blocked", 64'(s_re), 64'd0);
    flush_a = 1'b0;
    exp_a = 32'd22;
    cyc_a(1'b1);
    check("fl_valid_dropped", 64'(s_valid), 64'd0);
    for (int i = 0; i < 8; i++) cyc_a(1'b1);
    check("fl_pops", 64'(pops_a), 64'd2);
    check("fl_count", 64'(wc_a), 64'd6);

    // Asynchronous reset clears the counter before any clock edge
    reset = 1'b0;
    #1;
    check("arst_count", 64'(wc_a), 64'd0);
    check("arst_valid", 64'(ia.out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 17 words into a 4-bit counter wraps to 1
    for (int v = 24; v <= 40; v++) push_a(32'(v));
    clr_a();
    exp_a = 32'd24;
    for (int i = 0; i < 22; i++) cyc_a(1'b1);
    check("wrap_pops", 64'(pops_a), 64'd17);
    check("wrap_reads", 64'(re_cnt_a), 64'd17);
    check("wrap_count", 64'(wc_a), 64'd1);

    // Latency-2 reader under random ready and random empty, then drain
    enable_b = 1'b1;
    for (int i = 0; i < 1000; i++)
      cyc_b(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    enable_b = 1'b0;
    for (int i = 0; i < 8; i++) cyc_b(1'b1, 1'b1);
    check("b_drained", 64'(s_valid_b), 64'd0);
    check("b_all_delivered", 64'(issued_b), 64'(pops_b));
    check("b_count", 64'(wc_b), 64'(pops_b));
    check("b_progress", 64'(pops_b > 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
